lu_seq_ctrl: RTL and testbench
==============================

LU_SEQ_CTRL -- requirements
Module: lu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand/result width in bits (legal 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 3 bits: operation select, sampled with start.
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each: operands, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have port result, output, WIDTH bits: registered result, held until the next completion.
REQ-010 The block SHALL have port err, output, 1 bit: high with done when op was illegal; held until the next accepted start.
REQ-011 The block SHALL have port parity, output, 1 bit: see Configuration.

Function
REQ-012 The block SHALL evaluate one bit per cycle, LSB first, using a 1-bit logic cell with nb = ~b[i]: 000 ~a; 001 a&nb; 010 ~(a&nb); 011 a|nb; 100 ~(a|nb); 101 a^nb; 110 ~(a^nb).
REQ-013 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 and a legal op, the block SHALL capture op/a/b into shift registers, clear the bit counter and err, and go to RUN.
REQ-015 In IDLE with start=1 and op=111, the block SHALL go directly to DONE with err=1 and result=0.
REQ-016 In RUN, each edge SHALL shift one result bit in and increment the counter; after the WIDTH-th RUN edge the FSM SHALL enter DONE with the full result loaded.
REQ-017 Latency: start accepted at edge 0 SHALL give done=1 in the cycle after edge WIDTH for a legal op, or in the cycle after edge 0 for op=111.
REQ-018 The block SHALL assert done for exactly one cycle, in DONE, then return to IDLE.
REQ-019 The block SHALL ignore start in RUN and DONE, with no queuing; a start held high SHALL be re-sampled in IDLE.
REQ-020 The block SHALL drive busy=1 in RUN only and busy=0 in IDLE and DONE.
REQ-021 The result register SHALL change only on entry to DONE; intermediate bits SHALL never be visible on result.
REQ-022 Operand changes on a/b/op after acceptance SHALL NOT affect the running operation.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, counter=0 and busy, done, err, parity and result all 0, including mid-RUN.
REQ-024 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-025 With macro LU_SEQ_PARITY_EN defined, parity SHALL be registered as the XOR-reduce of the result on entry to DONE and held with result.
REQ-026 Without LU_SEQ_PARITY_EN, parity SHALL be tied to 0 and no parity logic SHALL be built; the port list SHALL be unchanged.

Structure
REQ-027 Shared package lu_pkg SHALL hold the op code constants (OP_NOT=000 ... OP_XNOR=110, OP_ILL=111), the FSM state encoding and the default WIDTH.
REQ-028 The 1-bit combinational logic cell SHALL be the sub-module lu_cell (inputs a, b, op; output y), instantiated once.

Verification
REQ-029 op=001, a=F0, b=0F, start at edge 0 -> busy for edges 1..8; done=1 after edge 8; result=F0; err=0.
REQ-030 op=000, a=5A, b=xx -> result=A5; op=101, a=AA, b=AA -> result=FF, parity=0 (with LU_SEQ_PARITY_EN).
REQ-031 op=111 -> done=1 in the cycle after acceptance, err=1, result=00, busy never 1.
REQ-032 start pulsed at RUN edge 3 with a different op -> ignored; first result correct; no second done.
REQ-033 rst_n=0 at RUN edge 4 -> busy/done/result=0 immediately; then op=011, a=00, b=FE -> result=01, parity=1 (macro on) or 0 (macro off).

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the bit-serial logic unit: op codes, FSM states, default width.
package lu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lu_cell.sv
// One-bit combinational logic cell; the b operand is inverted before the selected gate.
module lu_cell
  import lu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);

  logic nb;

  assign nb = ~b;

  always_comb begin
    // NOTE: y gets a default before the case so no op value can leave it unassigned and infer a latch.
    y = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & nb;
      OP_NAND: y = ~(a & nb);
      OP_OR:   y = a | nb;
      OP_NOR:  y = ~(a | nb);
      OP_XOR:  y = a ^ nb;
      OP_XNOR: y = ~(a ^ nb);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/lu_seq_ctrl.sv
// Bit-serial logic unit: evaluates one result bit per cycle, LSB first, through a single lu_cell.
// Optional macro LU_SEQ_PARITY_EN registers the XOR-reduce of each result on the parity port.
module lu_seq_ctrl
  import lu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             parity
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CNT_W-1:0] cnt;
  logic             cell_y;
  logic             accept, reject, last_bit;
  logic [WIDTH-1:0] res_full;

  assign accept   = (state == IDLE) && start && (op != OP_ILL);
  assign reject   = (state == IDLE) && start && (op == OP_ILL);
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign res_full = {cell_y, res_sh[WIDTH-1:1]};

  lu_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .op (op_q),
    .y  (cell_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (reject)      state_nxt = DONE;
        else if (accept) state_nxt = RUN;
      end
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift registers are reset along with the control state so a mid-run reset leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NOT;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      op_q   <= op;
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else if (reject) begin
      result <= '0;
      err    <= 1'b1;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= res_full;
      cnt    <= cnt + 1'b1;
      // Only the completed word ever reaches the visible result register.
      if (last_bit) result <= res_full;
    end
  end

`ifdef LU_SEQ_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        parity <= 1'b0;
    else if (reject)   parity <= 1'b0;
    else if (last_bit) parity <= ^res_full;
  end
`else
  assign parity = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_lu_seq_ctrl.sv
// Self-checking bench for lu_seq_ctrl: directed cases plus randomized ops against a word-level model.
module tb_lu_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, err, parity;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] prev_result = '0;

  lu_seq_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .parity (parity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-word reference of the op table (b is inverted before the gate).
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] ny;
    ny = ~y;
    case (o)
      3'b000:  return ~x;
      3'b001:  return x & ny;
      3'b010:  return ~(x & ny);
      3'b011:  return x | ny;
      3'b100:  return ~(x | ny);
      3'b101:  return x ^ ny;
      3'b110:  return ~(x ^ ny);
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_parity(input logic [W-1:0] r);
`ifdef LU_SEQ_PARITY_EN
    return ^r;
`else
    return 1'b0 & r[0];
`endif
  endfunction

  // Runs one operation; glitch>0 pulses start (different op) just before that RUN edge.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, input int glitch);
    logic [W-1:0] exp_r;
    logic         exp_e;
    int           lat, busy_cnt;
    bit           got, stable;
    exp_e = (o == 3'b111);
    exp_r = exp_e ? '0 : model(o, av, bv);
    lat = -1; busy_cnt = 0; got = 0; stable = 1;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    for (int k = 0; k <= W + 4; k++) begin
      if (done) begin lat = k; got = 1; break; end
      if (busy) busy_cnt++;
      if (result !== prev_result) stable = 0;
      if (k + 1 == glitch) begin start = 1'b1; op = o ^ 3'b010; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_seen", 32'(got), 32'(1));
    check("latency", 32'(lat), exp_e ? 32'(0) : 32'(W));
    check("busy_cycles", 32'(busy_cnt), exp_e ? 32'(0) : 32'(W));
    check("result_held", 32'(stable), 32'(1));
    check("result", 32'(result), 32'(exp_r));
    check("err", 32'(err), 32'(exp_e));
    check("parity", 32'(parity), 32'(exp_parity(exp_r)));
    check("busy_at_done", 32'(busy), 32'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("no_extra_done", 32'(done), 32'(0));
    end
    check("result_after", 32'(result), 32'(exp_r));
    check("err_after", 32'(err), 32'(exp_e));
    prev_result = exp_r;
  endtask

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_parity", 32'(parity), 32'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b001, 8'hF0, 8'h0F, 0);
    run_op(3'b000, 8'h5A, 8'h3C, 0);
    run_op(3'b101, 8'hAA, 8'hAA, 0);
    run_op(3'b111, 8'h12, 8'h34, 0);
    run_op(3'b010, 8'hC3, 8'h81, 3);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 8'h3C; b = 8'h96;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    check("mid_rst_result", 32'(result), 32'(0));
    check("mid_rst_err", 32'(err), 32'(0));
    check("mid_rst_parity", 32'(parity), 32'(0));
    prev_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b011, 8'h00, 8'hFE, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
